// File: rtl/klingon_seg_encoder.sv
// Seven-segment pattern recovery: debounces the segment lines, decodes a stable
// pattern to a hex digit and hands it to the consumer over a valid/ready handshake.
module klingon_seg_encoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       F,
  input  logic       G,
  input  logic       ready,
  output logic [3:0] O,
  output logic       valid,
  output logic       err
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    STABLE = 2'd1,
    OUT    = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] pat_in;
  logic [6:0] samp_p0;
  logic [3:0] cnt_p0;
  logic [3:0] cnt_nxt;
  logic [6:0] last_pat, last_pat_nxt;
  logic       changed;
  logic       accept;
  logic       load_out;
  logic [4:0] dec;

  // {hit, value}; hit=0 means the pattern is not a legal digit
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h7E:   seg_decode = {1'b1, 4'd0};
      7'h30:   seg_decode = {1'b1, 4'd1};
      7'h6D:   seg_decode = {1'b1, 4'd2};
      7'h79:   seg_decode = {1'b1, 4'd3};
      7'h33:   seg_decode = {1'b1, 4'd4};
      7'h5B:   seg_decode = {1'b1, 4'd5};
      7'h5F:   seg_decode = {1'b1, 4'd6};
      7'h70:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h7B:   seg_decode = {1'b1, 4'd9};
      7'h77:   seg_decode = {1'b1, 4'd10};
      7'h1F:   seg_decode = {1'b1, 4'd11};
      7'h4E:   seg_decode = {1'b1, 4'd12};
      7'h3D:   seg_decode = {1'b1, 4'd13};
      7'h4F:   seg_decode = {1'b1, 4'd14};
      7'h47:   seg_decode = {1'b1, 4'd15};
      default: seg_decode = 5'd0;
    endcase
  endfunction

  assign pat_in  = {A, B, C, D, E, F, G};
  assign changed = (pat_in != samp_p0);
  assign accept  = (cnt_p0 == CNT_MAX);
  assign dec     = seg_decode(samp_p0);
  assign valid   = (state == OUT);
  assign cnt_nxt = changed ? 4'd1 : (accept ? cnt_p0 : cnt_p0 + 4'd1);

  always_comb begin
    state_nxt    = state;
    last_pat_nxt = last_pat;
    load_out     = 1'b0;
    case (state)
      SETTLE: begin
        if (accept) begin
          // BLANK and repeats both leave last_pat equal to the accepted sample
          last_pat_nxt = samp_p0;
          if (samp_p0 != 7'd0 && samp_p0 != last_pat) begin
            state_nxt = OUT;
            load_out  = 1'b1;
          end else begin
            state_nxt = changed ? SETTLE : STABLE;
          end
        end
      end
      STABLE: begin
        if (changed) state_nxt = SETTLE;
      end
      OUT: begin
        if (ready) state_nxt = (pat_in != last_pat) ? SETTLE : STABLE;
      end
      default: state_nxt = SETTLE;
    endcase
  end

  // Sample/counter stage and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SETTLE;
      cnt_p0   <= 4'd0;
      samp_p0  <= 7'd0;
      last_pat <= 7'd0;
      O        <= 4'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt_p0   <= cnt_nxt;
      samp_p0  <= pat_in;
      last_pat <= last_pat_nxt;
      if (load_out) begin
        O   <= dec[4] ? dec[3:0] : 4'd0;
        err <= ~dec[4];
      end
    end
  end

endmodule

// File: tb/tb_klingon_seg_encoder.sv
// Directed bench for klingon_seg_encoder with STABLE_CYCLES=4.
module tb_klingon_seg_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       A, B, C, D, E, F, G;
  logic       ready;
  logic [3:0] O;
  logic       valid;
  logic       err;

  int         n_chk  = 0;
  int         n_pass = 0;
  int         emis   = 0;
  logic [3:0] em_o   = 4'd0;
  logic       em_err = 1'b0;
  logic       prev_valid = 1'b0;

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                          7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  klingon_seg_encoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .ready(ready), .O(O), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_pat(input logic [6:0] p);
    {A, B, C, D, E, F, G} = p;
  endtask

  // Advance n edges, sampling 1 time unit after each and logging each valid rise
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1 && prev_valid !== 1'b1) begin
        emis++;
        em_o   = O;
        em_err = err;
      end
      prev_valid = valid;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b1;
    set_pat(7'h00);
    step(2);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_o", 32'(O), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // digit 3, latency 5 edges, one-cycle valid
    rst_n = 1'b1;
    set_pat(7'h79);
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk($sformatf("lat_valid_e%0d", i), 32'(valid), (i == 5) ? 32'd1 : 32'd0);
      if (i == 5) begin
        chk("lat_o", 32'(O), 32'd3);
        chk("lat_err", 32'(err), 32'd0);
      end
    end

    // digit 5 held under backpressure, inputs wiggle while pending
    ready = 1'b0;
    set_pat(7'h5B);
    step(4);
    chk("bp_early", 32'(valid), 32'd0);
    step(1);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_o", 32'(O), 32'd5);
    set_pat(7'h7F);
    step(2);
    chk("bp_hold_valid", 32'(valid), 32'd1);
    chk("bp_hold_o", 32'({err, O}), 32'h05);
    set_pat(7'h5B);
    step(4);
    chk("bp_hold2_o", 32'({valid, err, O}), 32'h25);
    ready = 1'b1;
    step(1);
    chk("bp_xfer", 32'(valid), 32'd0);
    emis = 0;
    step(6);
    chk("bp_no_dup", 32'(emis), 32'd0);

    // illegal pattern
    set_pat(7'h60);
    step(5);
    chk("ill_valid", 32'(valid), 32'd1);
    chk("ill_err", 32'(err), 32'd1);
    chk("ill_o", 32'(O), 32'd0);
    step(1);
    chk("ill_drop", 32'(valid), 32'd0);

    // glitch restarts the count
    emis = 0;
    set_pat(7'h30); step(3);
    set_pat(7'h31); step(1);
    set_pat(7'h30); step(4);
    chk("gl_early", 32'({emis[3:0], valid}), 32'd0);
    step(1);
    chk("gl_valid", 32'(valid), 32'd1);
    chk("gl_o", 32'(O), 32'd1);
    step(5);
    chk("gl_count", 32'(emis), 32'd1);

    // 8, 8, BLANK, 8
    emis = 0;
    set_pat(7'h7F); step(12);
    chk("rep_first", 32'(emis), 32'd1);
    chk("rep_first_o", 32'(em_o), 32'd8);
    set_pat(7'h00); step(6);
    chk("rep_blank", 32'({emis[3:0], valid}), 32'h2);
    set_pat(7'h7F); step(6);
    chk("rep_second", 32'(emis), 32'd2);
    chk("rep_second_o", 32'({em_err, em_o}), 32'h08);

    // full table sweep with BLANK separators
    for (int k = 0; k < 16; k++) begin
      set_pat(7'h00); step(6);
      emis = 0;
      set_pat(tbl[k]); step(6);
      chk($sformatf("sweep_n%0d", k), 32'(emis), 32'd1);
      chk($sformatf("sweep_v%0d", k), 32'({em_err, em_o}), 32'(k));
    end

    // reset while a result is pending
    ready = 1'b0;
    set_pat(7'h30);
    step(5);
    chk("rp_valid", 32'({valid, O}), 32'h11);
    rst_n = 1'b0;
    step(1);
    chk("rp_cleared", 32'({valid, err, O}), 32'h00);
    rst_n = 1'b1;
    ready = 1'b1;
    emis = 0;
    step(7);
    chk("rp_reemit", 32'(emis), 32'd1);
    chk("rp_reemit_o", 32'({em_err, em_o}), 32'h01);

    // back-to-back: next pattern settles while previous is pending
    ready = 1'b0;
    set_pat(7'h6D);
    step(5);
    chk("b2b_first", 32'({valid, O}), 32'h12);
    set_pat(7'h79);
    step(6);
    chk("b2b_hold", 32'({valid, O}), 32'h12);
    ready = 1'b1;
    step(1);
    chk("b2b_gap", 32'(valid), 32'd0);
    step(1);
    chk("b2b_second", 32'({valid, err, O}), 32'h23);
    step(1);
    chk("b2b_done", 32'(valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/klingon_seg_encoder.md
KLINGON_SEG_ENCODER -- requirements
Module: klingon_seg_encoder

Interface
REQ-001 Parameter: STABLE_CYCLES, default 4, legal range 1..15; number of consecutive identical samples needed to accept a pattern.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Ports: A, B, C, D, E, F, G  input  1 each  segment lines, active-high; pattern written {A,B,C,D,E,F,G}, A = MSB.
REQ-005 Port: O  output  4  recovered digit value.
REQ-006 Port: valid  output  1  O/err hold a new result awaiting transfer.
REQ-007 Port: err  output  1  accepted pattern is not a legal digit.
REQ-008 Port: ready  input  1  consumer accepts the result; a transfer occurs on a rising edge with valid=1 and ready=1.

Function
REQ-009 Digit table, pattern -> O: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 1110111->10, 0011111->11, 1001110->12, 0111101->13, 1001111->14, 1000111->15.
REQ-010 Pattern 0000000 is BLANK; it is never emitted and never flagged as an error.
REQ-011 Each edge: register the inputs into the sample register; update the stability counter (saturating at STABLE_CYCLES); reload the counter to 1 whenever the new sample differs from the previous one.
REQ-012 A pattern is accepted on the edge where the counter reaches STABLE_CYCLES; valid rises on the next edge. Latency from the first edge with a new input to valid=1 is STABLE_CYCLES+1 edges.
REQ-013 FSM states: SETTLE (counting), STABLE (pattern accepted, no output pending), OUT (valid=1).
REQ-014 SETTLE -> OUT on acceptance when the pattern is non-BLANK and differs from last_pat; in the same edge, set last_pat to the pattern.
REQ-015 SETTLE -> STABLE on acceptance when the pattern is BLANK or equals last_pat; BLANK also sets last_pat to 0000000.
REQ-016 STABLE -> SETTLE on any sample change; the counter reloads to 1.
REQ-017 Entering OUT: a table hit drives O=value, err=0; a table miss drives O=0, err=1.
REQ-018 OUT: valid, O and err stay constant until transfer, whatever the inputs do.
REQ-019 OUT: the stability counter keeps running. On transfer, go to SETTLE if the current sample differs from last_pat, else to STABLE. valid falls on the transfer edge.
REQ-020 Back-to-back: a pattern that became stable while in OUT is accepted on the edge after transfer, so valid has at least one low cycle between results.
REQ-021 ready is ignored while valid=0; no result is ever dropped or duplicated.
REQ-022 The same digit is emitted again only if a BLANK or a different pattern was accepted in between.

Reset
REQ-023 When rst_n=0 at a rising edge: O=0, valid=0, err=0, state=SETTLE, counter=0, sample register=0000000, last_pat=0000000.
REQ-024 Reset has priority over everything, including an in-progress OUT; the pending result is discarded with no transfer.
REQ-025 Outputs are undefined only before the first reset edge; the bench always applies reset for at least 2 edges.

Verification
REQ-026 Reset, then pattern 1111001 held 6 cycles, ready=1, STABLE_CYCLES=4 -> valid=1 for exactly one cycle, 5 edges after the first sample; O=3, err=0.
REQ-027 Pattern 1011011 held with ready=0 for 10 cycles, then ready=1 -> valid stays high, O=5 constant; transfer on the first ready edge; no second emission.
REQ-028 Pattern 1100000 stable -> valid=1, err=1, O=0.
REQ-029 Glitch: 0110000 for 3 cycles, 0110001 for 1 cycle, then 0110000 for 5 cycles -> exactly one emission, O=1, latency counted from the last change.
REQ-030 Sequence 8, 8 (no gap), BLANK, 8 -> two emissions of O=8; sweep all 16 table entries with a BLANK between each -> O equals the table value, err=0.
REQ-031 rst_n=0 while valid=1 -> next edge valid=0, O=0, err=0; the same pattern held after reset is re-emitted.
